// File: rtl/me_window_sched_pkg.sv
// Shared types and row geometry for the motion-estimation search-window sequencer.
package me_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned ROW_PIX = 23;
    localparam int unsigned WIN_PIX = 16;
    localparam int unsigned ROW_W   = PIX_W * ROW_PIX;

    // Candidate positions of a WIN_PIX window sliding across one reference row.
    localparam int unsigned SHIFT_NUM_DEF = ROW_PIX - WIN_PIX + 1;
    localparam int unsigned ROW_NUM_DEF   = 16;
    localparam int unsigned ADDR_W_DEF    = 8;
    localparam int unsigned CNT_W_DEF     = 4;

endpackage

// File: rtl/me_window_sched_if.sv
// Control/status bundle between the search controller side and the window sequencer.
interface me_window_sched_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 4
);
    logic              start_i;
    logic              abort_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic              stall_i;
    logic              busy_o;
    logic              done_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              load_o;
    logic              cand_valid_o;
    logic [CNT_W-1:0]  row_cnt_o;
    logic [CNT_W-1:0]  shift_cnt_o;

    modport master (
        output start_i, abort_i, base_addr_i, stall_i,
        input  busy_o, done_o, rd_en_o, rd_addr_o, load_o, cand_valid_o,
               row_cnt_o, shift_cnt_o
    );

    modport slave (
        input  start_i, abort_i, base_addr_i, stall_i,
        output busy_o, done_o, rd_en_o, rd_addr_o, load_o, cand_valid_o,
               row_cnt_o, shift_cnt_o
    );
endinterface

// File: rtl/me_window_sched.sv
// Search-window row sequencer: fetches reference rows, strobes the row buffer and
// steps candidate positions for the SAD array, one macroblock search per start.
module me_window_sched
    import me_pkg::*;
#(
    parameter int unsigned ROW_NUM   = ROW_NUM_DEF,
    parameter int unsigned SHIFT_NUM = SHIFT_NUM_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    me_window_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_NUM - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;
    logic [CNT_W-1:0]  row_q, row_nxt;
    logic [CNT_W-1:0]  shift_q, shift_nxt;

    // State register together with the latched base and the row/shift counters.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            base_q  <= '0;
            row_q   <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_nxt;
            base_q  <= base_nxt;
            row_q   <= row_nxt;
            shift_q <= shift_nxt;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        row_nxt   = row_q;
        shift_nxt = shift_q;

        unique case (state)
            S_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    base_nxt  = bus.base_addr_i;
                    row_nxt   = '0;
                    shift_nxt = '0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                shift_nxt = '0;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (!bus.stall_i) begin
                    if (shift_q == SHIFT_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_nxt = S_DONE;
                        end else begin
                            row_nxt   = row_q + CNT_ONE;
                            state_nxt = S_FETCH;
                        end
                    end else begin
                        shift_nxt = shift_q + CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                row_nxt   = '0;
                shift_nxt = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Abort overrides stall and end-of-row decisions in every busy state.
        if (state != S_IDLE && bus.abort_i) begin
            row_nxt   = '0;
            shift_nxt = '0;
            state_nxt = S_IDLE;
        end
    end

    // Outputs decoded from the registered state; only cand_valid looks at stall.
    always_comb begin
        bus.busy_o       = 1'b0;
        bus.done_o       = 1'b0;
        bus.rd_en_o      = 1'b0;
        bus.rd_addr_o    = '0;
        bus.load_o       = 1'b0;
        bus.cand_valid_o = 1'b0;
        bus.row_cnt_o    = row_q;
        bus.shift_cnt_o  = shift_q;

        unique case (state)
            S_IDLE: ;
            S_FETCH: begin
                bus.busy_o    = 1'b1;
                bus.rd_en_o   = 1'b1;
                bus.rd_addr_o = base_q + ADDR_W'(row_q);
            end
            S_WAIT: begin
                bus.busy_o = 1'b1;
                bus.load_o = 1'b1;
            end
            S_SHIFT: begin
                bus.busy_o       = 1'b1;
                bus.cand_valid_o = !bus.stall_i;
            end
            S_DONE: begin
                bus.busy_o = 1'b1;
                bus.done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_me_window_sched.sv
// Directed scoreboard bench for me_window_sched: fetch addresses, strobe counts,
// search latency, stall, wrap, abort, reset and held-start behaviour.
module tb_me_window_sched;

    logic clk;
    logic rst_n;

    me_window_sched_if #(.ADDR_W(8), .CNT_W(4)) bus ();

    me_window_sched #(
        .ROW_NUM(16), .SHIFT_NUM(8), .ADDR_W(8), .CNT_W(4)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_load = 0;
    int         n_cand = 0;
    int         n_done = 0;
    int         done_cyc = 0;
    bit         mon_on = 1'b0;
    logic [7:0] sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: exclusivity, expected fetch addresses, strobe counts.
    task automatic sample();
        logic [7:0] exp_addr;
        if (mon_on) begin
            check("excl", 32'($countones({bus.rd_en_o, bus.load_o, bus.cand_valid_o}) <= 1), 32'd1);
            if (bus.rd_en_o) begin
                if (sb.size() != 0) exp_addr = sb.pop_front();
                else                exp_addr = 'x;
                check("rd_addr", 32'(bus.rd_addr_o), {24'd0, exp_addr});
            end
            n_load += int'(bus.load_o);
            n_cand += int'(bus.cand_valid_o);
            if (bus.done_o) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    endtask

    // Sample the current cycle at negedge, then move to just after the next posedge.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_search(input logic [7:0] base);
        for (int r = 0; r < 16; r++) sb.push_back(8'(base + 8'(r)));
        cyc = 0; n_load = 0; n_cand = 0; n_done = 0; done_cyc = 0;
        bus.base_addr_i = base;
        bus.start_i     = 1'b1;
    endtask

    task automatic wait_done(input int limit);
        while (n_done == 0 && cyc < limit) tick();
    endtask

    // Called in the cycle right after the done pulse.
    task automatic check_search(input string tag, input int exp_cyc);
        check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_cyc));
        check({tag, "_loads"}, 32'(n_load), 32'd16);
        check({tag, "_cands"}, 32'(n_cand), 32'd128);
        check({tag, "_idle"}, 32'({bus.busy_o, bus.row_cnt_o, bus.shift_cnt_o}), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.stall_i     = 1'b0;
        bus.base_addr_i = '0;

        // Reset held two cycles
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_outputs", 32'({bus.busy_o, bus.done_o, bus.rd_en_o, bus.load_o, bus.cand_valid_o,
                                    bus.rd_addr_o, bus.row_cnt_o, bus.shift_cnt_o}), 32'd0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Basic run
        begin_search(8'h10); tick(); bus.start_i = 1'b0;
        wait_done(400);
        check_search("basic", 161);

        // Five-cycle stall at row 0, shift 3
        begin_search(8'h20); tick(); bus.start_i = 1'b0;
        n = 0;
        while (!(bus.row_cnt_o == 4'd0 && bus.shift_cnt_o == 4'd3) && n < 50) begin tick(); n++; end
        check("stall_reach", 32'(bus.shift_cnt_o), 32'd3);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_shift", 32'(bus.shift_cnt_o), 32'd3);
            check("stall_cand", 32'(bus.cand_valid_o), 32'd0);
            tick();
        end
        bus.stall_i = 1'b0;
        wait_done(400);
        check_search("stall", 166);

        // Address wrap
        begin_search(8'hF8); tick(); bus.start_i = 1'b0;
        wait_done(400);
        check_search("wrap", 161);

        // Abort during row 5, shift 2, then immediate restart
        begin_search(8'h40); tick(); bus.start_i = 1'b0;
        n = 0;
        while (!(bus.row_cnt_o == 4'd5 && bus.shift_cnt_o == 4'd2) && n < 200) begin tick(); n++; end
        check("abort_reach", 32'({bus.row_cnt_o, bus.shift_cnt_o}), 32'h52);
        bus.abort_i = 1'b1; tick(); bus.abort_i = 1'b0;
        check("abort_idle", 32'({bus.busy_o, bus.row_cnt_o, bus.shift_cnt_o}), 32'd0);
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_rows_left", 32'(sb.size()), 32'd10);
        sb.delete();
        begin_search(8'h80); tick(); bus.start_i = 1'b0;
        check("restart_fetch", 32'({bus.rd_en_o, bus.rd_addr_o}), 32'h180);
        wait_done(400);
        check_search("restart", 161);

        // Reset asserted during FETCH
        begin_search(8'h50); tick(); bus.start_i = 1'b0;
        check("rst_mid_fetch", 32'(bus.rd_en_o), 32'd1);
        rst_n = 1'b0; tick();
        check("rst_mid_outputs", 32'({bus.busy_o, bus.done_o, bus.rd_en_o, bus.load_o, bus.cand_valid_o,
                                      bus.rd_addr_o, bus.row_cnt_o, bus.shift_cnt_o}), 32'd0);
        rst_n = 1'b1;
        sb.delete();

        // start held high: one search per IDLE entry
        begin_search(8'h60); tick();
        wait_done(400);
        check_search("held1", 161);
        begin_search(8'h60); tick();
        check("held_refetch", 32'({bus.rd_en_o, bus.rd_addr_o}), 32'h160);
        bus.start_i = 1'b0;
        wait_done(400);
        check_search("held2", 161);

        // abort together with stall on the last shift of the last row
        begin_search(8'h70); tick(); bus.start_i = 1'b0;
        n = 0;
        while (!(bus.row_cnt_o == 4'd15 && bus.shift_cnt_o == 4'd7 && bus.busy_o &&
                 !bus.rd_en_o && !bus.load_o) && n < 300) begin tick(); n++; end
        check("last_reach", 32'({bus.row_cnt_o, bus.shift_cnt_o}), 32'hF7);
        bus.abort_i = 1'b1; bus.stall_i = 1'b1; tick();
        bus.abort_i = 1'b0; bus.stall_i = 1'b0;
        check("last_abort_idle", 32'({bus.busy_o, bus.row_cnt_o, bus.shift_cnt_o}), 32'd0);
        tick(); tick();
        check("last_abort_no_done", 32'(n_done), 32'd0);
        check("last_abort_sb", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
